// File: rtl/decode_stage.sv
// RV32I decode: register file with write-back bypass, immediate/control decode, load-use detection.
// Latency 1 cycle to the ID/EX bundle; a downstream stall holds the bundle, a load-use hazard inserts a bubble.
module decode_stage #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] i_pipe_PC,
   input  logic [31:0]     i_pipe_Instruction,
   input  logic            i_pipe_stall,
   input  logic            i_flush,
   input  logic            i_ex_mem_read,
   input  logic [4:0]      i_ex_rd,
   input  logic            i_wb_en,
   input  logic [4:0]      i_wb_rd,
   input  logic [XLEN-1:0] i_wb_data,
   output logic            o_hazard_stall,
   output logic            o_pipe_valid,
   output logic [XLEN-1:0] o_pipe_PC,
   output logic [XLEN-1:0] o_pipe_rs1_data,
   output logic [XLEN-1:0] o_pipe_rs2_data,
   output logic [31:0]     o_pipe_imm,
   output logic [4:0]      o_pipe_rs1,
   output logic [4:0]      o_pipe_rs2,
   output logic [4:0]      o_pipe_rd,
   output logic [2:0]      o_pipe_funct3,
   output logic            o_pipe_funct7b5,
   output logic            o_pipe_reg_write,
   output logic            o_pipe_mem_read,
   output logic            o_pipe_mem_write,
   output logic            o_pipe_alu_src_imm,
   output logic            o_pipe_branch,
   output logic            o_pipe_jump
);
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [31:0]     imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [2:0]      funct3;
      logic            funct7b5;
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
      logic            alu_src_imm;
      logic            branch;
      logic            jump;
   } idex_t;

   logic [XLEN-1:0] regs [32];
   logic [31:0]     ins;
   logic [6:0]      opcode;
   logic [4:0]      rs1, rs2;
   logic [31:0]     imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [XLEN-1:0] rs1_val, rs2_val;
   logic            rs1_used, rs2_used;
   idex_t           dec, bubble, idex_q;

   assign ins    = i_pipe_Instruction;
   assign opcode = ins[6:0];
   assign rs1    = ins[19:15];
   assign rs2    = ins[24:20];

   assign imm_i = {{20{ins[31]}}, ins[31:20]};
   assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
   assign imm_b = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
   assign imm_u = {ins[31:12], 12'b0};
   assign imm_j = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};

   // Write-back in the same cycle wins over the stored value.
   assign rs1_val = (rs1 == 5'd0) ? '0 :
                    (i_wb_en && i_wb_rd == rs1) ? i_wb_data : regs[rs1];
   assign rs2_val = (rs2 == 5'd0) ? '0 :
                    (i_wb_en && i_wb_rd == rs2) ? i_wb_data : regs[rs2];

   always_comb begin
      bubble    = '0;
      bubble.pc = RESET_PC;
   end

   // Unrecognised opcodes decode to a bubble so EX never sees stale fields.
   always_comb begin
      dec          = bubble;
      rs1_used     = 1'b1;
      rs2_used     = 1'b0;
      case (opcode)
         OP_LUI, OP_AUIPC: begin
            dec.valid = 1'b1; dec.reg_write = 1'b1; dec.alu_src_imm = 1'b1;
            dec.imm = imm_u; rs1_used = 1'b0;
         end
         OP_JAL: begin
            dec.valid = 1'b1; dec.reg_write = 1'b1; dec.jump = 1'b1;
            dec.imm = imm_j; rs1_used = 1'b0;
         end
         OP_JALR: begin
            dec.valid = 1'b1; dec.reg_write = 1'b1; dec.jump = 1'b1;
            dec.alu_src_imm = 1'b1; dec.imm = imm_i;
         end
         OP_BRANCH: begin
            dec.valid = 1'b1; dec.branch = 1'b1; dec.imm = imm_b; rs2_used = 1'b1;
         end
         OP_LOAD: begin
            dec.valid = 1'b1; dec.reg_write = 1'b1; dec.mem_read = 1'b1;
            dec.alu_src_imm = 1'b1; dec.imm = imm_i;
         end
         OP_STORE: begin
            dec.valid = 1'b1; dec.mem_write = 1'b1; dec.alu_src_imm = 1'b1;
            dec.imm = imm_s; rs2_used = 1'b1;
         end
         OP_IMM: begin
            dec.valid = 1'b1; dec.reg_write = 1'b1; dec.alu_src_imm = 1'b1; dec.imm = imm_i;
         end
         OP_OP: begin
            dec.valid = 1'b1; dec.reg_write = 1'b1; rs2_used = 1'b1;
         end
         default: ;
      endcase
      if (dec.valid) begin
         dec.pc       = i_pipe_PC;
         dec.rs1_data = rs1_val;
         dec.rs2_data = rs2_val;
         dec.rs1      = rs1;
         dec.rs2      = rs2;
         dec.rd       = ins[11:7];
         dec.funct3   = ins[14:12];
         dec.funct7b5 = ins[30];
      end
   end

   assign o_hazard_stall = !i_flush && i_ex_mem_read && (i_ex_rd != 5'd0) &&
                           ((i_ex_rd == rs1 && rs1_used) || (i_ex_rd == rs2 && rs2_used));

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (i_wb_en && i_wb_rd != 5'd0) begin
         regs[i_wb_rd] <= i_wb_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || i_flush)   idex_q <= bubble;
      else if (i_pipe_stall)  idex_q <= idex_q;
      else if (o_hazard_stall) idex_q <= bubble;
      else                    idex_q <= dec;
   end

   assign o_pipe_valid       = idex_q.valid;
   assign o_pipe_PC          = idex_q.pc;
   assign o_pipe_rs1_data    = idex_q.rs1_data;
   assign o_pipe_rs2_data    = idex_q.rs2_data;
   assign o_pipe_imm         = idex_q.imm;
   assign o_pipe_rs1         = idex_q.rs1;
   assign o_pipe_rs2         = idex_q.rs2;
   assign o_pipe_rd          = idex_q.rd;
   assign o_pipe_funct3      = idex_q.funct3;
   assign o_pipe_funct7b5    = idex_q.funct7b5;
   assign o_pipe_reg_write   = idex_q.reg_write;
   assign o_pipe_mem_read    = idex_q.mem_read;
   assign o_pipe_mem_write   = idex_q.mem_write;
   assign o_pipe_alu_src_imm = idex_q.alu_src_imm;
   assign o_pipe_branch      = idex_q.branch;
   assign o_pipe_jump        = idex_q.jump;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed cases with literal expectations, then randomized traffic
// compared every cycle against an instruction-level reference model.
module tb_decode_stage;
   typedef struct packed {
      logic        valid;
      logic [31:0] pc, rs1d, rs2d, imm;
      logic [4:0]  rs1, rs2, rd;
      logic [2:0]  f3;
      logic        f7, rw, mr, mw, ai, br, jp;
   } bnd_t;

   logic        clk = 0, reset = 1;
   logic [31:0] i_pipe_PC = 0, i_pipe_Instruction = 32'h00500093;
   logic        i_pipe_stall = 0, i_flush = 0, i_ex_mem_read = 0, i_wb_en = 0;
   logic [4:0]  i_ex_rd = 0, i_wb_rd = 0;
   logic [31:0] i_wb_data = 0;
   logic        o_hazard_stall, o_pipe_valid, o_pipe_funct7b5;
   logic [31:0] o_pipe_PC, o_pipe_rs1_data, o_pipe_rs2_data, o_pipe_imm;
   logic [4:0]  o_pipe_rs1, o_pipe_rs2, o_pipe_rd;
   logic [2:0]  o_pipe_funct3;
   logic        o_pipe_reg_write, o_pipe_mem_read, o_pipe_mem_write;
   logic        o_pipe_alu_src_imm, o_pipe_branch, o_pipe_jump;

   int n_vec = 0, n_err = 0;

   decode_stage dut (
      .clk(clk), .reset(reset), .i_pipe_PC(i_pipe_PC), .i_pipe_Instruction(i_pipe_Instruction),
      .i_pipe_stall(i_pipe_stall), .i_flush(i_flush), .i_ex_mem_read(i_ex_mem_read),
      .i_ex_rd(i_ex_rd), .i_wb_en(i_wb_en), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
      .o_hazard_stall(o_hazard_stall), .o_pipe_valid(o_pipe_valid), .o_pipe_PC(o_pipe_PC),
      .o_pipe_rs1_data(o_pipe_rs1_data), .o_pipe_rs2_data(o_pipe_rs2_data),
      .o_pipe_imm(o_pipe_imm), .o_pipe_rs1(o_pipe_rs1), .o_pipe_rs2(o_pipe_rs2),
      .o_pipe_rd(o_pipe_rd), .o_pipe_funct3(o_pipe_funct3), .o_pipe_funct7b5(o_pipe_funct7b5),
      .o_pipe_reg_write(o_pipe_reg_write), .o_pipe_mem_read(o_pipe_mem_read),
      .o_pipe_mem_write(o_pipe_mem_write), .o_pipe_alu_src_imm(o_pipe_alu_src_imm),
      .o_pipe_branch(o_pipe_branch), .o_pipe_jump(o_pipe_jump)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [31:0] mregs [32];
   bnd_t        exp_b;
   bit          model_ready = 0;

   function automatic logic rs1_used(input logic [6:0] op);
      return !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
   endfunction

   function automatic logic rs2_used(input logic [6:0] op);
      return op == 7'h63 || op == 7'h23 || op == 7'h33;
   endfunction

   function automatic logic hazard_of();
      logic [31:0] ins;
      ins = i_pipe_Instruction;
      if (i_flush || !i_ex_mem_read || i_ex_rd == 0) return 1'b0;
      return (i_ex_rd == ins[19:15] && rs1_used(ins[6:0])) ||
             (i_ex_rd == ins[24:20] && rs2_used(ins[6:0]));
   endfunction

   function automatic logic [31:0] rd_reg(input logic [4:0] r);
      if (r == 0) return 0;
      if (i_wb_en && i_wb_rd == r) return i_wb_data;
      return mregs[r];
   endfunction

   // Immediates rebuilt as weighted sums of instruction fields minus a sign offset.
   function automatic bnd_t decode(input logic [31:0] ins, input logic [31:0] pc);
      bnd_t b;
      logic [31:0] sgn;
      b = '0;
      sgn = {31'b0, ins[31]};
      case (ins[6:0])
         7'h37, 7'h17: begin b.rw = 1; b.ai = 1; b.imm = ins & 32'hFFFFF000; end
         7'h6F: begin b.rw = 1; b.jp = 1;
            b.imm = ins[19:12] * 4096 + ins[20] * 2048 + ins[30:21] * 2 - sgn * 32'h100000; end
         7'h67: begin b.rw = 1; b.jp = 1; b.ai = 1; b.imm = ins[31:20] - sgn * 4096; end
         7'h63: begin b.br = 1;
            b.imm = ins[7] * 2048 + ins[30:25] * 32 + ins[11:8] * 2 - sgn * 4096; end
         7'h03: begin b.rw = 1; b.mr = 1; b.ai = 1; b.imm = ins[31:20] - sgn * 4096; end
         7'h23: begin b.mw = 1; b.ai = 1; b.imm = ins[31:25] * 32 + ins[11:7] - sgn * 4096; end
         7'h13: begin b.rw = 1; b.ai = 1; b.imm = ins[31:20] - sgn * 4096; end
         7'h33: b.rw = 1;
         default: return '0;
      endcase
      b.valid = 1;
      b.pc = pc;
      b.rs1 = ins[19:15]; b.rs2 = ins[24:20]; b.rd = ins[11:7];
      b.f3 = ins[14:12]; b.f7 = ins[30];
      b.rs1d = rd_reg(b.rs1); b.rs2d = rd_reg(b.rs2);
      return b;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         exp_b = '0;
         for (int i = 0; i < 32; i++) mregs[i] = 0;
      end else begin
         if (i_flush)              exp_b = '0;
         else if (i_pipe_stall)    exp_b = exp_b;
         else if (hazard_of())     exp_b = '0;
         else                      exp_b = decode(i_pipe_Instruction, i_pipe_PC);
         if (i_wb_en && i_wb_rd != 0) mregs[i_wb_rd] = i_wb_data;
      end
      model_ready = 1;
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      bnd_t act;
      logic hz;
      hz = hazard_of();
      n_vec++;
      if (o_hazard_stall !== hz) begin
         n_err++;
         $display("FAIL hazard_stall @%0t: got %b expected %b", $time, o_hazard_stall, hz);
      end
      if (model_ready) begin
         act = {o_pipe_valid, o_pipe_PC, o_pipe_rs1_data, o_pipe_rs2_data, o_pipe_imm,
                o_pipe_rs1, o_pipe_rs2, o_pipe_rd, o_pipe_funct3, o_pipe_funct7b5,
                o_pipe_reg_write, o_pipe_mem_read, o_pipe_mem_write, o_pipe_alu_src_imm,
                o_pipe_branch, o_pipe_jump};
         n_vec++;
         if (act !== exp_b) begin
            n_err++;
            $display("FAIL idex_bundle @%0t: got %h expected %h", $time, act, exp_b);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle();
      i_pipe_stall = 0; i_flush = 0; i_ex_mem_read = 0; i_ex_rd = 0;
      i_wb_en = 0; i_wb_rd = 0; i_wb_data = 0;
   endtask

   logic [6:0] ops [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

   initial begin
      logic [31:0] ins;
      // 1: reset, then first instruction
      tick(); tick();
      chk("reset_valid", {31'b0, o_pipe_valid}, 0);
      chk("reset_pc", o_pipe_PC, 0);
      chk("reset_imm", o_pipe_imm, 0);
      chk("reset_rw", {31'b0, o_pipe_reg_write}, 0);
      chk("reset_hazard", {31'b0, o_hazard_stall}, 0);
      reset = 0; i_pipe_PC = 32'h4;
      tick();
      chk("addi_valid", {31'b0, o_pipe_valid}, 1);
      chk("addi_rd", {27'b0, o_pipe_rd}, 1);
      chk("addi_rs1", {27'b0, o_pipe_rs1}, 0);
      chk("addi_imm", o_pipe_imm, 5);
      chk("addi_ctl", {30'b0, o_pipe_reg_write, o_pipe_alu_src_imm}, 3);
      // 2: immediates
      i_pipe_Instruction = 32'hFE000EE3; tick();
      chk("beq_imm", o_pipe_imm, 32'hFFFFFFFC);
      chk("beq_branch", {31'b0, o_pipe_branch}, 1);
      i_pipe_Instruction = 32'h0030A423; tick();
      chk("sw_imm", o_pipe_imm, 8);
      chk("sw_rs2", {27'b0, o_pipe_rs2}, 3);
      chk("sw_mw", {31'b0, o_pipe_mem_write}, 1);
      i_pipe_Instruction = 32'h123452B7; tick();
      chk("lui_imm", o_pipe_imm, 32'h12345000);
      // 3: bypass and x0
      i_wb_en = 1; i_wb_rd = 1; i_wb_data = 32'hDEADBEEF; i_pipe_Instruction = 32'h001101B3;
      tick();
      chk("bypass_rs2", o_pipe_rs2_data, 32'hDEADBEEF);
      i_wb_en = 0; tick();
      chk("stored_rs2", o_pipe_rs2_data, 32'hDEADBEEF);
      i_wb_en = 1; i_wb_rd = 0; i_wb_data = 32'h55; i_pipe_Instruction = 32'h00000033; tick();
      chk("x0_bypass", o_pipe_rs1_data, 0);
      i_wb_en = 0; tick();
      chk("x0_read", o_pipe_rs1_data, 0);
      // 4: load-use
      i_ex_mem_read = 1; i_ex_rd = 2; i_pipe_Instruction = 32'h001101B3; #1;
      chk("lu_stall", {31'b0, o_hazard_stall}, 1);
      tick();
      chk("lu_bubble", {31'b0, o_pipe_valid}, 0);
      i_ex_rd = 0; #1;
      chk("lu_rd0", {31'b0, o_hazard_stall}, 0);
      i_ex_rd = 2; i_pipe_Instruction = 32'h00500093; #1;
      chk("lu_nors2", {31'b0, o_hazard_stall}, 0);
      // 5: priority
      i_pipe_Instruction = 32'h001101B3; i_flush = 1; #1;
      chk("flush_stall", {31'b0, o_hazard_stall}, 0);
      tick();
      chk("flush_bubble", {31'b0, o_pipe_valid}, 0);
      idle(); i_pipe_PC = 32'h100; tick();
      chk("held_valid", {31'b0, o_pipe_valid}, 1);
      i_pipe_stall = 1; i_wb_en = 1; i_wb_rd = 2; i_wb_data = 32'h12345678;
      i_pipe_Instruction = 32'h0030A423; i_pipe_PC = 32'h200;
      for (int i = 0; i < 3; i++) begin
         tick();
         i_wb_en = 0;
         chk("stall_pc", o_pipe_PC, 32'h100);
      end
      i_pipe_stall = 0; i_pipe_Instruction = 32'h001101B3; tick();
      chk("wb_during_stall", o_pipe_rs1_data, 32'h12345678);
      // 6: reset while stalled
      i_pipe_stall = 1; reset = 1; tick();
      chk("rst_stall_valid", {31'b0, o_pipe_valid}, 0);
      chk("rst_stall_pc", o_pipe_PC, 0);
      reset = 0; i_pipe_stall = 0; tick();
      chk("rst_x1", o_pipe_rs2_data, 0);
      // randomized traffic, checked by the per-cycle compare
      for (int n = 0; n < 3000; n++) begin
         int k;
         k = $urandom_range(0, 10);
         ins = $urandom;
         if (k < 9) ins[6:0] = ops[k];
         else if (k == 9) ins = 0;
         ins[11:7] = 5'($urandom_range(0, 7));
         ins[19:15] = 5'($urandom_range(0, 7));
         ins[24:20] = 5'($urandom_range(0, 7));
         i_pipe_Instruction = ins;
         i_pipe_PC = $urandom & 32'hFFFFFFFC;
         reset = ($urandom_range(0, 99) < 2);
         i_flush = ($urandom_range(0, 9) == 0);
         i_pipe_stall = ($urandom_range(0, 99) < 15);
         i_ex_mem_read = ($urandom_range(0, 9) < 3);
         i_ex_rd = 5'($urandom_range(0, 7));
         i_wb_en = $urandom_range(0, 1) == 1;
         i_wb_rd = 5'($urandom_range(0, 7));
         i_wb_data = $urandom;
         tick();
      end
      @(negedge clk); #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
